// File: rtl/hilo_mul_stage_pkg.sv
// Shared CPU package: state encoding, word and product widths
// for the HI/LO multiply stage.
package hilo_mul_stage_pkg;

  localparam int WORD   = 32;
  localparam int PROD_W = 2 * WORD;

  typedef logic [WORD-1:0]   word_t;
  typedef logic [PROD_W-1:0] prod_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/booth_radix4_mul.sv
// Combinational signed 32x32->64 multiplier using radix-4
// (bit-pair) Booth recoding of the multiplier operand.
module booth_radix4_mul
  import hilo_mul_stage_pkg::*;
(
  input  word_t i_a,
  input  word_t i_b,
  output prod_t o_prod
);

  logic [WORD:0]   w_bx;
  prod_t           w_a64;
  prod_t           w_pp;
  prod_t           w_acc;
  logic [2:0]      w_trip;

  assign w_bx  = {i_b, 1'b0};
  assign w_a64 = {{WORD{i_a[WORD-1]}}, i_a};

  // Each overlapping bit triplet selects 0, +-A or +-2A.
  always_comb begin
    w_acc  = '0;
    w_pp   = '0;
    w_trip = '0;
    for (int i = 0; i < WORD / 2; i++) begin
      w_trip = w_bx[2*i +: 3];
      unique case (w_trip)
        3'b001, 3'b010: w_pp = w_a64;
        3'b011:         w_pp = w_a64 << 1;
        3'b100:         w_pp = -(w_a64 << 1);
        3'b101, 3'b110: w_pp = -w_a64;
        default:        w_pp = '0;
      endcase
      w_acc = w_acc + (w_pp << (2 * i));
    end
  end

  assign o_prod = w_acc;

endmodule

// File: rtl/hilo_mul_stage.sv
// HI/LO product registers with a multi-cycle settle window
// around the combinational Booth multiplier.
module hilo_mul_stage
  import hilo_mul_stage_pkg::*;
#(
  parameter int MUL_CYCLES = 2,
  parameter int CNT_W      = 4
) (
  input  logic            clock,
  input  logic            clear,
  input  logic            start,
  input  logic [WORD-1:0] op_a,
  input  logic [WORD-1:0] op_b,
  input  logic [WORD-1:0] hi_in,
  input  logic [WORD-1:0] lo_in,
  input  logic            hi_wr,
  input  logic            lo_wr,
  output logic            busy,
  output logic            done,
  output logic [WORD-1:0] hi_out,
  output logic [WORD-1:0] lo_out
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_CYCLES - 1);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  word_t            r_a;
  word_t            r_b;
  word_t            r_hi;
  word_t            r_lo;
  prod_t            w_prod;

  booth_radix4_mul u_mul (
    .i_a    (r_a),
    .i_b    (r_b),
    .o_prod (w_prod)
  );

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      unique case (r_state)
        ST_CALC: begin
          if (r_cnt == '0) begin
            r_hi    <= w_prod[PROD_W-1:WORD];
            r_lo    <= w_prod[WORD-1:0];
            r_state <= ST_DONE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_IDLE, ST_DONE: begin
          if (hi_wr) r_hi <= hi_in;
          if (lo_wr) r_lo <= lo_in;
          if (start) begin
            r_a     <= op_a;
            r_b     <= op_b;
            r_cnt   <= CNT_LOAD;
            r_state <= ST_CALC;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy   = (r_state == ST_CALC);
  assign done   = (r_state == ST_DONE);
  assign hi_out = r_hi;
  assign lo_out = r_lo;

endmodule

// File: tb/tb_hilo_mul_stage.sv
// Directed bench for hilo_mul_stage with a cycle-level
// reference model and per-cycle output comparison.
module tb_hilo_mul_stage;

  localparam int MC = 2;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic        start = 1'b0;
  logic [31:0] op_a  = '0;
  logic [31:0] op_b  = '0;
  logic [31:0] hi_in = '0;
  logic [31:0] lo_in = '0;
  logic        hi_wr = 1'b0;
  logic        lo_wr = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  int n_vec = 0;
  int n_err = 0;

  hilo_mul_stage #(.MUL_CYCLES(MC), .CNT_W(4)) dut (
    .clock  (clock),
    .clear  (clear),
    .start  (start),
    .op_a   (op_a),
    .op_b   (op_b),
    .hi_in  (hi_in),
    .lo_in  (lo_in),
    .hi_wr  (hi_wr),
    .lo_wr  (lo_wr),
    .busy   (busy),
    .done   (done),
    .hi_out (hi_out),
    .lo_out (lo_out)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: edge counting, the pending capture edge
  // and the product computed with plain signed arithmetic.
  longint      m_k    = 0;
  longint      m_cap  = -1;
  longint      m_done = -1;
  logic [63:0] m_prod = '0;
  logic [31:0] m_hi   = '0;
  logic [31:0] m_lo   = '0;

  always @(posedge clock or posedge clear) begin
    if (clear) begin
      m_cap  = -1;
      m_done = -1;
      m_hi   = '0;
      m_lo   = '0;
    end else begin
      m_k = m_k + 1;
      if (m_cap == m_k) begin
        m_hi   = m_prod[63:32];
        m_lo   = m_prod[31:0];
        m_done = m_k;
        m_cap  = -1;
      end else if (m_cap < 0) begin
        if (hi_wr) m_hi = hi_in;
        if (lo_wr) m_lo = lo_in;
        if (start) begin
          m_prod = 64'(longint'($signed(op_a)) *
                       longint'($signed(op_b)));
          m_cap  = m_k + MC;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (!clear) begin
      chk("hi", 64'(hi_out), 64'(m_hi));
      chk("lo", 64'(lo_out), 64'(m_lo));
      chk("busy", 64'(busy), 64'(m_cap >= 0));
      chk("done", 64'(done), 64'(m_done == m_k));
      chk("excl", 64'(busy & done), 64'd0);
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Drives start for one edge; returns just after the capture edge.
  task automatic mul(input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    cyc();
    start = 1'b0;
    repeat (MC) cyc();
  endtask

  initial begin
    repeat (2) cyc();
    chk("rst_hi", 64'(hi_out), 64'd0);
    chk("rst_lo", 64'(lo_out), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    clear = 1'b0;
    cyc();

    start = 1'b1; op_a = 32'd6; op_b = 32'd7;
    cyc();
    start = 1'b0;
    chk("6x7_busy", 64'(busy), 64'd1);
    cyc();
    chk("6x7_busy1", 64'(busy), 64'd1);
    cyc();
    chk("6x7_hi", 64'(hi_out), 64'h0);
    chk("6x7_lo", 64'(lo_out), 64'h2A);
    chk("6x7_done", 64'(done), 64'd1);
    cyc();
    chk("6x7_done_end", 64'(done), 64'd0);

    mul(32'hFFFFFFFD, 32'h5);
    chk("neg_hi", 64'(hi_out), 64'hFFFFFFFF);
    chk("neg_lo", 64'(lo_out), 64'hFFFFFFF1);
    cyc();
    mul(32'h80000000, 32'h80000000);
    chk("min_hi", 64'(hi_out), 64'h40000000);
    chk("min_lo", 64'(lo_out), 64'h0);
    cyc();

    start = 1'b1; op_a = 32'h7FFFFFFF; op_b = 32'd2;
    cyc();
    start = 1'b0; op_a = 32'd0;
    repeat (MC) cyc();
    chk("iso_hi", 64'(hi_out), 64'h0);
    chk("iso_lo", 64'(lo_out), 64'hFFFFFFFE);
    start = 1'b1; op_a = 32'd3; op_b = 32'd3;
    cyc();
    start = 1'b0;
    chk("b2b_busy", 64'(busy), 64'd1);
    repeat (MC - 1) cyc();
    chk("b2b_pre", 64'(lo_out), 64'hFFFFFFFE);
    cyc();
    chk("b2b_lo", 64'(lo_out), 64'd9);
    cyc();

    start = 1'b1; op_a = 32'd2; op_b = 32'd2;
    cyc();
    op_a = 32'd9; op_b = 32'd9;
    hi_wr = 1'b1; hi_in = 32'hDEADBEEF;
    cyc();
    start = 1'b0; hi_wr = 1'b0;
    cyc();
    chk("ign_hi", 64'(hi_out), 64'h0);
    chk("ign_lo", 64'(lo_out), 64'd4);
    repeat (4) cyc();

    hi_wr = 1'b1; hi_in = 32'h12345678;
    cyc();
    hi_wr = 1'b0;
    chk("wr_hi", 64'(hi_out), 64'h12345678);
    chk("wr_hi_lo", 64'(lo_out), 64'd4);
    lo_wr = 1'b1; lo_in = 32'hCAFEF00D;
    cyc();
    lo_wr = 1'b0;
    chk("wr_lo", 64'(lo_out), 64'hCAFEF00D);
    chk("wr_lo_hi", 64'(hi_out), 64'h12345678);

    start = 1'b1; op_a = 32'd1; op_b = 32'd1;
    hi_wr = 1'b1; hi_in = 32'h0000ABCD;
    cyc();
    start = 1'b0; hi_wr = 1'b0;
    chk("sw_hi_first", 64'(hi_out), 64'hABCD);
    repeat (MC) cyc();
    chk("sw_hi_over", 64'(hi_out), 64'h0);
    chk("sw_lo_over", 64'(lo_out), 64'd1);
    cyc();

    start = 1'b1; op_a = 32'd5; op_b = 32'd5;
    cyc();
    start = 1'b0;
    #1 clear = 1'b1;
    #1;
    chk("clr_hi", 64'(hi_out), 64'h0);
    chk("clr_lo", 64'(lo_out), 64'h0);
    chk("clr_busy", 64'(busy), 64'd0);
    chk("clr_done", 64'(done), 64'd0);
    clear = 1'b0;
    repeat (4) cyc();
    mul(32'd5, 32'd5);
    chk("post_clr_lo", 64'(lo_out), 64'd25);
    repeat (2) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
